// File: rtl/fetch_pkg.sv
// Shared fetch definitions: FSM state encodings, PC step default and address helpers.
// Used by the fetch controller and the decode queue.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_BUBBLE  = 2'd2,
        ST_SYSWAIT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_STEP_DEFAULT = 32'h4;
    localparam logic [31:0] WORD_BYTES      = 32'h4;
    localparam int          CNT_W           = 16;
    localparam logic [15:0] STALL_MAX       = 16'hFFFF;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: redirect/stall inputs and fetch address/strobe outputs.
// master = the fetch controller, slave = the pipeline environment around it.
interface fetch_ctrl_if;

    logic [31:0] PC_init;
    logic        flush_fCOM;
    logic        mispredict;
    logic [31:0] nextInstruction_address;
    logic        syscall_detect;
    logic        syscall_retire;
    logic        FREEZE;
    logic        full_IDQUEUE;

    logic [31:0] Instr_address_2IM;
    logic [31:0] CIA;
    logic        do_write_IDQUEUE;
    logic        pipe_kill;
    logic [1:0]  fetch_state;
    logic [15:0] stall_count;

    modport master (
        input  PC_init, flush_fCOM, mispredict, nextInstruction_address,
               syscall_detect, syscall_retire, FREEZE, full_IDQUEUE,
        output Instr_address_2IM, CIA, do_write_IDQUEUE, pipe_kill,
               fetch_state, stall_count
    );

    modport slave (
        output PC_init, flush_fCOM, mispredict, nextInstruction_address,
               syscall_detect, syscall_retire, FREEZE, full_IDQUEUE,
        input  Instr_address_2IM, CIA, do_write_IDQUEUE, pipe_kill,
               fetch_state, stall_count
    );

endinterface

// File: rtl/fetch_hold_cnt.sv
// Down-counter timing the INIT and BUBBLE hold phases of the fetch FSM.
// Reset loads RESET_VALUE, load takes load_value, dec stops at zero.
module fetch_hold_cnt #(
    parameter int             W           = 16,
    parameter logic [W-1:0]   RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential PC generation with stall, redirect,
// bubble and syscall-drain handling, feeding the decode queue.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          INIT_CYCLES   = 2,
    parameter int          BUBBLE_CYCLES = 1,
    parameter logic [31:0] PC_STEP       = PC_STEP_DEFAULT
) (
    input  logic          CLK,
    input  logic          RESET,
    fetch_ctrl_if.master  bus
);

    localparam logic [CNT_W-1:0] INIT_LOAD   = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BUBBLE_LOAD = CNT_W'(BUBBLE_CYCLES - 1);

    fetch_state_e state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  cia, cia_next;
    logic [15:0]  stall, stall_next;
    logic [31:0]  redirect_target;
    logic         cnt_load, cnt_dec, cnt_zero;
    logic         write_raw, kill_raw;

    assign redirect_target = align_word(bus.nextInstruction_address);

    fetch_hold_cnt #(
        .W           (CNT_W),
        .RESET_VALUE (INIT_LOAD)
    ) u_hold_cnt (
        .clk        (CLK),
        .reset      (RESET),
        .load       (cnt_load),
        .load_value (BUBBLE_LOAD),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_INIT;
            pc    <= bus.PC_init;
            cia   <= '0;
            stall <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            cia   <= cia_next;
            stall <= stall_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        cia_next   = cia;
        stall_next = stall;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        write_raw  = 1'b0;
        kill_raw   = 1'b0;

        if (bus.flush_fCOM) begin
            kill_raw   = 1'b1;
            pc_next    = bus.PC_init;
            cia_next   = '0;
            state_next = ST_BUBBLE;
            cnt_load   = 1'b1;
        end else if (bus.mispredict) begin
            kill_raw   = 1'b1;
            pc_next    = redirect_target;
            // CIA looks like the word before the target was the last fetch.
            cia_next   = redirect_target - WORD_BYTES;
            state_next = ST_BUBBLE;
            cnt_load   = 1'b1;
        end else begin
            unique case (state)
                ST_INIT, ST_BUBBLE: begin
                    if (cnt_zero) state_next = ST_RUN;
                    else          cnt_dec    = 1'b1;
                end
                ST_RUN: begin
                    if (bus.syscall_detect) begin
                        state_next = ST_SYSWAIT;
                    end else if (bus.FREEZE || bus.full_IDQUEUE) begin
                        if (stall != STALL_MAX) stall_next = stall + 16'd1;
                    end else begin
                        write_raw = 1'b1;
                        pc_next   = pc + PC_STEP;
                        cia_next  = pc;
                    end
                end
                ST_SYSWAIT: begin
                    if (bus.syscall_retire) state_next = ST_RUN;
                end
                default: state_next = ST_INIT;
            endcase
        end
    end

    // Combinational strobes are silenced while reset is held.
    assign bus.do_write_IDQUEUE  = write_raw && !RESET;
    assign bus.pipe_kill         = kill_raw && !RESET;
    assign bus.Instr_address_2IM = pc;
    assign bus.CIA               = cia;
    assign bus.fetch_state       = state;
    assign bus.stall_count       = stall;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed stimulus, a cycle-level reference
// model compared every cycle, and hand-computed literal checkpoints.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .INIT_CYCLES   (2),
        .BUBBLE_CYCLES (1),
        .PC_STEP       (32'h4)
    ) dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase (0 init,1 run,2 bubble,3 syscall wait), addresses,
    // stall tally and remaining hold cycles in the current init/bubble phase.
    bit          m_valid = 1'b0;
    int          m_phase;
    logic [31:0] m_pc, m_cia;
    int          m_stall, m_hold;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_phase = 0;
            m_hold  = 2 - 1;
            m_pc    = bus.PC_init;
            m_cia   = 0;
            m_stall = 0;
        end else if (m_valid) begin
            if (bus.flush_fCOM) begin
                m_pc = bus.PC_init; m_cia = 0; m_phase = 2; m_hold = 0;
            end else if (bus.mispredict) begin
                m_pc  = bus.nextInstruction_address & ~32'd3;
                m_cia = m_pc - 32'd4;
                m_phase = 2; m_hold = 0;
            end else if (m_phase == 0 || m_phase == 2) begin
                if (m_hold == 0) m_phase = 1;
                else             m_hold  = m_hold - 1;
            end else if (m_phase == 1) begin
                if (bus.syscall_detect)                 m_phase = 3;
                else if (bus.FREEZE || bus.full_IDQUEUE) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
                else begin m_cia = m_pc; m_pc = m_pc + 32'd4; end
            end else if (bus.syscall_retire) begin
                m_phase = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_write", 32'(bus.do_write_IDQUEUE),
                  32'(!reset && m_phase == 1 && !bus.flush_fCOM && !bus.mispredict &&
                      !bus.syscall_detect && !bus.FREEZE && !bus.full_IDQUEUE));
            check("m_kill",  32'(bus.pipe_kill), 32'(!reset && (bus.flush_fCOM || bus.mispredict)));
            check("m_pc",    bus.Instr_address_2IM, m_pc);
            check("m_cia",   bus.CIA, m_cia);
            check("m_state", 32'(bus.fetch_state), 32'(m_phase));
            check("m_stall", 32'(bus.stall_count), 32'(m_stall));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.PC_init = 32'h0040_0000;
        bus.flush_fCOM = 0; bus.mispredict = 0; bus.nextInstruction_address = 0;
        bus.syscall_detect = 0; bus.syscall_retire = 0; bus.FREEZE = 0; bus.full_IDQUEUE = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_state", 32'(bus.fetch_state), 32'd0);
        check("rst_pc",    bus.Instr_address_2IM, 32'h0040_0000);
        check("rst_cia",   bus.CIA, 32'h0);
        check("rst_stall", 32'(bus.stall_count), 32'd0);
        check("init_wr0",  32'(bus.do_write_IDQUEUE), 32'd0);
        tick(); #1 check("init_wr1", 32'(bus.do_write_IDQUEUE), 32'd0);
        tick(); #1 check("run_wr_a", 32'(bus.do_write_IDQUEUE), 32'd1);
        check("run_pc_a", bus.Instr_address_2IM, 32'h0040_0000);
        tick(); #1 check("run_pc_b", bus.Instr_address_2IM, 32'h0040_0004);
        check("run_cia_b", bus.CIA, 32'h0040_0000);
        tick(); #1 check("run_pc_c", bus.Instr_address_2IM, 32'h0040_0008);
        tick(); tick();
        bus.full_IDQUEUE = 1;
        #1 check("stall_wr", 32'(bus.do_write_IDQUEUE), 32'd0);
        tick(); tick(); tick();
        bus.full_IDQUEUE = 0;
        #1 check("stall_cnt", 32'(bus.stall_count), 32'd3);
        check("stall_pc", bus.Instr_address_2IM, 32'h0040_0010);
        check("stall_resume", 32'(bus.do_write_IDQUEUE), 32'd1);
        tick(); tick(); tick(); tick();
        bus.syscall_detect = 1;
        #1 check("sys_pc", bus.Instr_address_2IM, 32'h0040_0020);
        check("sys_wr", 32'(bus.do_write_IDQUEUE), 32'd0);
        tick();
        bus.syscall_detect = 0;
        repeat (4) tick();
        bus.syscall_retire = 1;
        #1 check("syswait_state", 32'(bus.fetch_state), 32'd3);
        tick();
        bus.syscall_retire = 0;
        #1 check("sys_resume_wr", 32'(bus.do_write_IDQUEUE), 32'd1);
        check("sys_resume_pc", bus.Instr_address_2IM, 32'h0040_0020);
        tick();
        bus.syscall_detect = 1;
        tick();
        bus.mispredict = 1; bus.nextInstruction_address = 32'h0040_0103;
        #1 check("sysmis_kill", 32'(bus.pipe_kill), 32'd1);
        tick();
        bus.mispredict = 0; bus.syscall_detect = 0;
        #1 check("mis_bubble_state", 32'(bus.fetch_state), 32'd2);
        check("mis_bubble_wr", 32'(bus.do_write_IDQUEUE), 32'd0);
        tick();
        #1 check("mis_wr", 32'(bus.do_write_IDQUEUE), 32'd1);
        check("mis_pc",  bus.Instr_address_2IM, 32'h0040_0100);
        check("mis_cia", bus.CIA, 32'h0040_00FC);
        tick();
        bus.mispredict = 1;
        #1 check("run_mis_kill", 32'(bus.pipe_kill), 32'd1);
        tick(); bus.mispredict = 0;
        tick(); #1 check("run_mis_pc", bus.Instr_address_2IM, 32'h0040_0100);
        check("run_mis_cia", bus.CIA, 32'h0040_00FC);
        tick();
        bus.flush_fCOM = 1; bus.mispredict = 1; bus.nextInstruction_address = 32'h1234_5678;
        #1 check("flush_kill", 32'(bus.pipe_kill), 32'd1);
        tick();
        bus.flush_fCOM = 0; bus.mispredict = 0;
        #1 check("flush_pc", bus.Instr_address_2IM, 32'h0040_0000);
        check("flush_cia", bus.CIA, 32'h0);
        check("flush_state", 32'(bus.fetch_state), 32'd2);
        tick(); tick();
        bus.mispredict = 1; bus.nextInstruction_address = 32'hFFFF_FFFF;
        tick(); bus.mispredict = 0;
        tick(); #1 check("wrap_pc", bus.Instr_address_2IM, 32'hFFFF_FFFC);
        check("wrap_cia", bus.CIA, 32'hFFFF_FFF8);
        tick(); #1 check("wrap_next", bus.Instr_address_2IM, 32'h0000_0000);
        bus.FREEZE = 1;
        repeat (65537) tick();
        bus.FREEZE = 0;
        #1 check("stall_sat", 32'(bus.stall_count), 32'h0000_FFFF);
        bus.syscall_retire = 1;
        tick();
        bus.syscall_retire = 0; bus.syscall_detect = 1;
        tick();
        bus.syscall_detect = 0;
        #1 check("sys2_state", 32'(bus.fetch_state), 32'd3);
        tick();
        reset = 1; bus.flush_fCOM = 1; bus.mispredict = 1;
        #1 check("rst_kill", 32'(bus.pipe_kill), 32'd0);
        check("rst_wr", 32'(bus.do_write_IDQUEUE), 32'd0);
        tick();
        reset = 0; bus.flush_fCOM = 0; bus.mispredict = 0;
        #1 check("rst2_state", 32'(bus.fetch_state), 32'd0);
        check("rst2_stall", 32'(bus.stall_count), 32'd0);
        check("rst2_pc", bus.Instr_address_2IM, 32'h0040_0000);
        tick(); tick();
        #1 check("rst2_wr", 32'(bus.do_write_IDQUEUE), 32'd1);
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter INIT_CYCLES, default 2, number of post-reset cycles PC is held at PC_init with no fetch.
REQ-002 Parameter BUBBLE_CYCLES, default 1, number of fetch-suppressed cycles after a redirect (flush or mispredict).
REQ-003 Parameter PC_STEP, default 32'h4, sequential PC increment.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RESET  in  1  reset; synchronous, active-high.
REQ-006 PC_init  in  32  program entry address, used at reset and flush.
REQ-007 flush_fCOM  in  1  commit-stage flush request.
REQ-008 mispredict  in  1  branch redirect request.
REQ-009 nextInstruction_address  in  32  redirect target accompanying mispredict.
REQ-010 syscall_detect  in  1  ID saw a syscall; fetch must drain.
REQ-011 syscall_retire  in  1  COM retired the syscall; fetch may resume.
REQ-012 FREEZE  in  1  global pipeline freeze.
REQ-013 full_IDQUEUE  in  1  decode queue cannot accept a write.
REQ-014 Instr_address_2IM  out  32  registered fetch PC driven to instruction memory.
REQ-015 CIA  out  32  registered address of the most recently written fetch.
REQ-016 do_write_IDQUEUE  out  1  combinational write strobe to decode queue.
REQ-017 pipe_kill  out  1  combinational; squash in-flight IF/ID contents this cycle.
REQ-018 fetch_state  out  2  current FSM state encoding.
REQ-019 stall_count  out  16  saturating count of RUN-state stall cycles.

Function
REQ-020 FSM states SHALL be INIT=0, RUN=1, BUBBLE=2, SYSWAIT=3.
REQ-021 Event priority SHALL be flush_fCOM > mispredict > syscall_detect > FREEZE/full_IDQUEUE, evaluated every cycle in every state except during RESET.
REQ-022 INIT: do_write_IDQUEUE=0; PC holds PC_init; a down-counter loaded with INIT_CYCLES-1 reaches 0 -> RUN; INIT_CYCLES=1 exits after one cycle.
REQ-023 RUN: do_write_IDQUEUE = !FREEZE && !full_IDQUEUE && no higher-priority event; on write, next PC = PC + PC_STEP (mod 2^32, wrap without flag) and CIA <= current PC.
REQ-024 RUN with FREEZE or full_IDQUEUE and no other event: PC and CIA hold; stall_count increments, saturating at 16'hFFFF.
REQ-025 flush_fCOM in any state: pipe_kill=1 same cycle, do_write_IDQUEUE=0, next PC = PC_init, CIA <= 0, next state BUBBLE with counter BUBBLE_CYCLES-1.
REQ-026 mispredict (no flush): pipe_kill=1, do_write_IDQUEUE=0, next PC = {nextInstruction_address[31:2],2'b00}, CIA <= that aligned target - 4, next state BUBBLE.
REQ-027 BUBBLE: do_write_IDQUEUE=0, PC holds; counter reaches 0 -> RUN; a new flush/mispredict in BUBBLE reloads target and counter.
REQ-028 syscall_detect in RUN (no flush/mispredict): do_write_IDQUEUE=0 that cycle, PC holds, next state SYSWAIT.
REQ-029 SYSWAIT: do_write_IDQUEUE=0, PC holds; syscall_retire -> RUN next cycle; syscall_detect ignored; flush/mispredict override per REQ-025/026.
REQ-030 syscall_retire outside SYSWAIT and syscall_detect outside RUN SHALL have no effect.
REQ-031 pipe_kill SHALL be 0 whenever neither flush_fCOM nor mispredict is asserted, and 0 during RESET.
REQ-032 fetch_state SHALL reflect the registered state, not the next state.

Reset
REQ-033 RESET high at a rising edge SHALL set state=INIT, counter=INIT_CYCLES-1, Instr_address_2IM=PC_init, CIA=0, stall_count=0, overriding all other inputs including flush/mispredict.
REQ-034 While RESET is high, do_write_IDQUEUE=0 and pipe_kill=0; reset asserted mid-SYSWAIT or mid-BUBBLE discards that state.

Structure
REQ-035 State encodings and PC_STEP default SHALL live in shared package fetch_pkg, reused by IF and the decode queue.
REQ-036 Bubble/init down-counter SHALL be one sub-module, fetch_hold_cnt (load, decrement, zero flag); everything else flat.

Verification
REQ-037 Reset with PC_init=0x00400000, INIT_CYCLES=2 -> no write for 2 cycles, then writes at 0x00400000, 0x00400004, 0x00400008 on consecutive cycles.
REQ-038 In RUN at PC 0x00400010, full_IDQUEUE high 3 cycles -> PC holds, stall_count=3, resume at 0x00400010.
REQ-039 mispredict with target 0x00400103 -> pipe_kill same cycle, 1 bubble cycle, next write at 0x00400100 with CIA=0x004000FC.
REQ-040 flush_fCOM and mispredict same cycle -> PC_init taken, CIA=0, state BUBBLE.
REQ-041 syscall_detect at 0x00400020, retire 5 cycles later -> no writes in between, resume write at 0x00400020; mispredict during SYSWAIT redirects and exits.
REQ-042 PC=0xFFFFFFFC write -> next PC 0x00000000; RESET asserted in SYSWAIT -> INIT, stall_count=0.
